// File: rtl/score_digit_renderer_pkg.sv
// Shared constants and types for the score text layer: glyph geometry,
// font-ROM address width, character codes and the BCD digit type.
package score_digit_renderer_pkg;

    localparam int         CHAR_W     = 8;
    localparam int         CHAR_H     = 16;
    localparam int         ROM_AW     = 11;
    localparam logic [6:0] ASCII_ZERO = 7'h30;
    localparam logic [6:0] CHAR_BLANK = 7'h00;

    typedef logic [3:0] bcd_digit_t;

    // Glyph code for one digit slot; blanked slots use the all-zero glyph.
    function automatic logic [6:0] digit_char(input bcd_digit_t d, input logic blank);
        return blank ? CHAR_BLANK : ASCII_ZERO + {3'b000, d};
    endfunction

endpackage

// File: rtl/score_digit_renderer_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; it saturates at all-9s
// instead of wrapping. Digit 0 is the least significant digit.
module score_digit_renderer_bcd_counter
    import score_digit_renderer_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inc,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] value
);

    logic [4*NUM_DIGITS-1:0] incremented;
    logic                    all_nines;
    bcd_digit_t              d;

    // all_nines doubles as the ripple carry: it survives the loop only when
    // every digit was 9, which is exactly the saturation condition.
    // NOTE: every variable gets a default before the loop, so no latch is inferred.
    always_comb begin
        incremented = value;
        all_nines   = 1'b1;
        d           = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = value[4*i +: 4];
            if (all_nines) begin
                if (d == 4'd9) begin
                    incremented[4*i +: 4] = 4'd0;
                end else begin
                    incremented[4*i +: 4] = d + 4'd1;
                    all_nines             = 1'b0;
                end
            end
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !all_nines) begin
            value <= incremented;
        end
    end

endmodule

// File: rtl/score_digit_renderer.sv
// Score text layer: BCD current/high scores, font-ROM address generation from
// the VGA pixel position and a 3-clock pixel pipeline around the registered ROM.
module score_digit_renderer
    import score_digit_renderer_pkg::*;
#(
    parameter int         NUM_DIGITS = 4,
    parameter logic [9:0] ORIGIN_X   = 10'd16,
    parameter logic [9:0] ORIGIN_Y   = 10'd16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic                    video_on,
    input  logic                    score_inc,
    input  logic                    score_clr,
    input  logic                    game_over,
    output logic [ROM_AW-1:0]       rom_addr,
    input  logic [7:0]              rom_data,
    output logic                    text_on,
    output logic [4*NUM_DIGITS-1:0] cur_score,
    output logic [4*NUM_DIGITS-1:0] high_score,
    output logic                    new_record
);

    localparam logic [10:0] X_END = {1'b0, ORIGIN_X} + 11'(CHAR_W * NUM_DIGITS);
    localparam logic [10:0] Y_END = {1'b0, ORIGIN_Y} + 11'(2 * CHAR_H);

    score_digit_renderer_bcd_counter #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_cur_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (score_inc),
        .clr   (score_clr),
        .value (cur_score)
    );

    // Compare sees the registered cur_score, i.e. before a same-clock increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            high_score <= '0;
            new_record <= 1'b0;
        end else if (game_over && (cur_score > high_score)) begin
            high_score <= cur_score;
            new_record <= 1'b1;
        end else if (score_clr) begin
            new_record <= 1'b0;
        end
    end

    logic [9:0]              dx;
    logic [4:0]              dy;
    logic [6:0]              slot;
    logic                    in_region;
    logic [4*NUM_DIGITS-1:0] line_score;
    logic                    lead_zero;
    bcd_digit_t              digit;
    logic                    blank;
    logic [6:0]              char_code;

    // Wrapped dx/dy values never matter: the region test uses the raw x/y.
    assign dx        = x - ORIGIN_X;
    assign dy        = 5'(y - ORIGIN_Y);
    assign slot      = dx[9:3];
    assign in_region = video_on
                     && (x >= ORIGIN_X) && ({1'b0, x} < X_END)
                     && (y >= ORIGIN_Y) && ({1'b0, y} < Y_END);
    assign line_score = dy[4] ? high_score : cur_score;

    // Walk from the MSD down; a digit is blanked while all digits at or above
    // it are zero, except the LSD which always shows.
    always_comb begin
        lead_zero = 1'b1;
        digit     = '0;
        blank     = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (line_score[4*i +: 4] == 4'd0);
            if (slot == 7'(NUM_DIGITS - 1 - i)) begin
                digit = line_score[4*i +: 4];
                blank = lead_zero && (i != 0);
            end
        end
        char_code = in_region ? digit_char(digit, blank) : CHAR_BLANK;
    end

    logic [2:0] col_d1;
    logic [2:0] col_d2;
    logic       in_region_d1;
    logic       in_region_d2;

    // Column and region flag ride two stages so they meet the ROM's row data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr     <= '0;
            col_d1       <= '0;
            col_d2       <= '0;
            in_region_d1 <= 1'b0;
            in_region_d2 <= 1'b0;
            text_on      <= 1'b0;
        end else begin
            rom_addr     <= {char_code, dy[3:0]};
            col_d1       <= dx[2:0];
            in_region_d1 <= in_region;
            col_d2       <= col_d1;
            in_region_d2 <= in_region_d1;
            text_on      <= in_region_d2 & rom_data[3'd7 - col_d2];
        end
    end

endmodule
